branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch resolution controller for the RV32I core. It sits between decode and the shared branch comparator. It accepts one branch or jump at a time, drives the comparator's select and operand lines, interprets its Eq/Lt result, computes the target, and issues a PC redirect plus a multi-cycle pipeline flush when the branch is taken. Misaligned targets and reserved branch encodings are reported, not redirected.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: cycles `flush` stays high after a taken redirect; legal range 1–15.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  decode presents a branch or jump.
- br_ready  out  1  controller can accept; equals (state==IDLE).
- is_jal, is_jalr  in  1 each  unconditional jumps; at most one is high, and neither is high for a conditional branch.
- funct3  in  3  branch condition, used only when both jump flags are low.
- pc, imm, rs1_val, rs2_val  in  32 each  instruction PC, sign-extended immediate, operands.
- comp_sel  out  3  comparator select.
- comp_un  out  1  comparator unsigned flag; equals comp_sel[1].
- comp_a, comp_b  out  32 each  comparator operands.
- comp_eq, comp_lt  in  1 each  comparator results. These are combinational from comp_sel, comp_a and comp_b.
- resolve_valid  out  1  one-cycle pulse when a branch completes.
- resolve_taken  out  1  qualifies resolve_valid.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  32  new PC; valid while redirect_valid is high.
- flush  out  1  squash younger instructions.
- illegal  out  1  pulse; reserved funct3 (010, 011).
- misalign  out  1  pulse; taken target with target[1:0] != 0.
- stat_branches, stat_taken  out  32 each  performance counters; see Configuration.

## Operation
- States: IDLE, CMP, FLUSH.
- IDLE:
  - On br_valid && br_ready, latch pc, imm, rs1_val, rs2_val, funct3, is_jal and is_jalr.
  - Go to CMP.
- CMP:
  - Drive comp_sel = latched funct3, or 000 for jumps.
  - Drive comp_a = rs1_val and comp_b = rs2_val from the latched values.
  - Taken condition:
    - funct3 000 → comp_eq.
    - funct3 001 → !comp_eq.
    - funct3 1xx → comp_lt (the comparator already inverts the sense for 101 and 111).
    - funct3 010 or 011 → not taken, and illegal fires.
    - Jumps → always taken.
- Target:
  - Branch or JAL: pc + imm.
  - JALR: (rs1_val + imm) & ~1.
  - All 32-bit arithmetic, wrapping modulo 2^32.
- Exit from CMP:
  - Taken with target[1:0] == 0 → go to FLUSH.
  - Not taken, illegal, or misaligned → go to IDLE.
- FLUSH: a down-counter loads FLUSH_CYCLES−1 on entry. Return to IDLE when the counter reads 0.
- comp_a, comp_b and comp_sel hold their latched values in every state. They reset to 0.
- A misaligned taken branch raises misalign only: no redirect_valid, no flush, and resolve_taken = 1.

## Timing
- Reset:
  - state = IDLE.
  - Every registered output is 0: resolve_*, redirect_*, flush, illegal, misalign, comp_*, stat_*.
  - br_ready is 0 during the reset cycle and 1 in the cycle after.
- Accept edge T. CMP is cycle T+1, and all resolution outputs are registered at the end of T+1.
- Not taken:
  - resolve_valid pulses in T+2 with resolve_taken = 0.
  - br_ready is high again in T+2, so back-to-back branches can be accepted every 2 cycles.
- Taken:
  - resolve_valid, resolve_taken and redirect_valid pulse in T+2.
  - flush is high in cycles T+2 through T+1+FLUSH_CYCLES.
  - br_ready returns the cycle after flush drops.
- While busy, br_valid is ignored and decode holds the branch.
- Reset asserted in any state aborts the branch within the same cycle. No pulse is emitted for the aborted branch.

## Configuration
- `BRANCH_CTRL_STATS_EN` defined:
  - stat_branches increments on every resolve_valid.
  - stat_taken increments on every resolve_valid && resolve_taken.
  - Both wrap from 0xFFFFFFFF to 0 and are cleared by rst.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- BEQ, rs1 = rs2 = 5, pc = 0x100, imm = 0x20 → T+2: redirect_valid = 1, redirect_pc = 0x120; flush high 2 cycles; br_ready high at T+4.
- BLTU, rs1 = 0xFFFFFFFF, rs2 = 1 → comp_sel = 110, comp_un = 1; not taken; resolve_valid = 1, resolve_taken = 0 in T+2; no flush.
- BGE, rs1 = 0xFFFFFFFF (−1), rs2 = 1 → not taken. Then BLT with the same operands → taken.
- JALR, rs1 = 0x203, imm = 0 → target 0x202 → misalign = 1, redirect_valid = 0, flush = 0; back in IDLE at T+2.
- funct3 = 010 → illegal pulse in T+2, resolve_taken = 0. Then rst asserted in the middle of FLUSH → all outputs 0 the next cycle, br_ready = 1 the cycle after.
- With `BRANCH_CTRL_STATS_EN`: 3 taken + 2 not-taken branches → stat_branches = 5, stat_taken = 3. Without the macro: both read 0.

Source files
------------

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_ctrl
//  Description : RV32I branch resolution controller. Accepts one branch/jump
//                at a time, drives the shared comparator, resolves the taken
//                condition, computes the target and issues a PC redirect
//                followed by a multi-cycle pipeline flush. Misaligned targets
//                and reserved funct3 encodings are reported, not redirected.
//                Optional performance counters: BRANCH_CTRL_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [2:0]  comp_sel,
    output logic        comp_un,
    output logic [31:0] comp_a,
    output logic [31:0] comp_b,
    input  logic        comp_eq,
    input  logic        comp_lt,
    output logic        resolve_valid,
    output logic        resolve_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        illegal,
    output logic        misalign,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
);

    localparam int unsigned c_CNT_W    = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_pc;
    logic [31:0]         r_imm;
    logic                r_is_jal;
    logic                r_is_jalr;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_is_jump;
    logic                w_illegal;
    logic                w_taken;
    logic                w_misalign;
    logic [31:0]         w_target;

    // Ready is suppressed during the reset cycle itself.
    assign br_ready  = (r_state == IDLE) && !rst;
    assign comp_un   = comp_sel[1];

    // comp_sel already holds 000 for jumps, so the condition decode keys off it.
    assign w_is_jump = r_is_jal | r_is_jalr;
    assign w_illegal = !w_is_jump && (comp_sel[2:1] == 2'b01);

    // Taken decode from the comparator result (comparator handles 101/111 inversion).
    always_comb begin
        w_taken = 1'b0;
        if (w_is_jump) begin
            w_taken = 1'b1;
        end else begin
            case (comp_sel)
                3'b000:  w_taken = comp_eq;
                3'b001:  w_taken = !comp_eq;
                3'b100,
                3'b101,
                3'b110,
                3'b111:  w_taken = comp_lt;
                default: w_taken = 1'b0;
            endcase
        end
    end

    // JALR uses the latched rs1 (held on comp_a) and clears bit 0.
    assign w_target   = r_is_jalr ? ((comp_a + r_imm) & ~32'd1) : (r_pc + r_imm);
    assign w_misalign = w_taken && (w_target[1:0] != 2'b00);

    // Control FSM with registered resolution outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_pc           <= '0;
            r_imm          <= '0;
            r_is_jal       <= 1'b0;
            r_is_jalr      <= 1'b0;
            r_cnt          <= '0;
            comp_sel       <= '0;
            comp_a         <= '0;
            comp_b         <= '0;
            resolve_valid  <= 1'b0;
            resolve_taken  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            illegal        <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            resolve_valid  <= 1'b0;
            resolve_taken  <= 1'b0;
            redirect_valid <= 1'b0;
            illegal        <= 1'b0;
            misalign       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (br_valid) begin
                        r_pc      <= pc;
                        r_imm     <= imm;
                        r_is_jal  <= is_jal;
                        r_is_jalr <= is_jalr;
                        comp_a    <= rs1_val;
                        comp_b    <= rs2_val;
                        comp_sel  <= (is_jal || is_jalr) ? 3'b000 : funct3;
                        r_state   <= CMP;
                    end
                end
                CMP: begin
                    resolve_valid <= 1'b1;
                    resolve_taken <= w_taken;
                    illegal       <= w_illegal;
                    misalign      <= w_misalign;
                    if (w_taken && !w_misalign) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= w_target;
                        flush          <= 1'b1;
                        r_cnt          <= c_CNT_INIT;
                        r_state        <= FLUSH;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        flush   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_taken;

    // Performance counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_taken    <= '0;
        end else if (resolve_valid) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (resolve_taken) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_taken    = r_stat_taken;
`else
    assign stat_branches = '0;
    assign stat_taken    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_ctrl
//  Description : Directed self-checking bench for branch_ctrl, including a
//                behavioural model of the shared branch comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [2:0]  comp_sel;
    logic        comp_un;
    logic [31:0] comp_a;
    logic [31:0] comp_b;
    logic        comp_eq;
    logic        comp_lt;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        illegal;
    logic        misalign;
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;

    int n_tests = 0;
    int n_fail  = 0;

    branch_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .is_jal         (is_jal),
        .is_jalr        (is_jalr),
        .funct3         (funct3),
        .pc             (pc),
        .imm            (imm),
        .rs1_val        (rs1_val),
        .rs2_val        (rs2_val),
        .comp_sel       (comp_sel),
        .comp_un        (comp_un),
        .comp_a         (comp_a),
        .comp_b         (comp_b),
        .comp_eq        (comp_eq),
        .comp_lt        (comp_lt),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .illegal        (illegal),
        .misalign       (misalign),
        .stat_branches  (stat_branches),
        .stat_taken     (stat_taken)
    );

    always #5 clk = ~clk;

    // Shared comparator: 101/111 return the inverted (>=) sense on comp_lt.
    always_comb begin
        comp_eq = (comp_a == comp_b);
        case (comp_sel)
            3'b100:  comp_lt = ($signed(comp_a) < $signed(comp_b));
            3'b101:  comp_lt = !($signed(comp_a) < $signed(comp_b));
            3'b110:  comp_lt = (comp_a < comp_b);
            3'b111:  comp_lt = !(comp_a < comp_b);
            default: comp_lt = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a branch on the current cycle; accepted at the next rising edge.
    task automatic present(input logic jal, input logic jalr, input logic [2:0] f3,
                           input logic [31:0] p, input logic [31:0] im,
                           input logic [31:0] a, input logic [31:0] b);
        br_valid = 1'b1;
        is_jal   = jal;
        is_jalr  = jalr;
        funct3   = f3;
        pc       = p;
        imm      = im;
        rs1_val  = a;
        rs2_val  = b;
    endtask

    initial begin
        rst = 1'b1;
        present(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        br_valid = 1'b0;

        // ---------------- reset ----------------
        step();
        check("rst_br_ready",   {31'd0, br_ready}, 32'd0);
        check("rst_resolve",    {31'd0, resolve_valid}, 32'd0);
        check("rst_redirect",   {31'd0, redirect_valid}, 32'd0);
        check("rst_redir_pc",   redirect_pc, 32'd0);
        check("rst_flush",      {31'd0, flush}, 32'd0);
        check("rst_comp_sel",   {29'd0, comp_sel}, 32'd0);
        check("rst_comp_a",     comp_a, 32'd0);
        check("rst_stat_br",    stat_branches, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", {31'd0, br_ready}, 32'd1);

        // ---------------- BEQ taken ----------------
        present(1'b0, 1'b0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        step();                       // T+1
        br_valid = 1'b0;
        check("beq_t1_ready",   {31'd0, br_ready}, 32'd0);
        check("beq_t1_sel",     {29'd0, comp_sel}, 32'd0);
        check("beq_t1_a",       comp_a, 32'd5);
        check("beq_t1_b",       comp_b, 32'd5);
        step();                       // T+2
        check("beq_rv",         {31'd0, resolve_valid}, 32'd1);
        check("beq_rt",         {31'd0, resolve_taken}, 32'd1);
        check("beq_redir",      {31'd0, redirect_valid}, 32'd1);
        check("beq_redir_pc",   redirect_pc, 32'h120);
        check("beq_flush2",     {31'd0, flush}, 32'd1);
        check("beq_ready2",     {31'd0, br_ready}, 32'd0);
        step();                       // T+3
        check("beq_flush3",     {31'd0, flush}, 32'd1);
        check("beq_redir3",     {31'd0, redirect_valid}, 32'd0);
        check("beq_rv3",        {31'd0, resolve_valid}, 32'd0);
        check("beq_ready3",     {31'd0, br_ready}, 32'd0);
        step();                       // T+4
        check("beq_flush4",     {31'd0, flush}, 32'd0);
        check("beq_ready4",     {31'd0, br_ready}, 32'd1);

        // ---------------- BLTU not taken ----------------
        present(1'b0, 1'b0, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1);
        step();
        br_valid = 1'b0;
        check("bltu_sel",       {29'd0, comp_sel}, 32'd6);
        check("bltu_un",        {31'd0, comp_un}, 32'd1);
        step();
        check("bltu_rv",        {31'd0, resolve_valid}, 32'd1);
        check("bltu_rt",        {31'd0, resolve_taken}, 32'd0);
        check("bltu_flush",     {31'd0, flush}, 32'd0);
        check("bltu_redir",     {31'd0, redirect_valid}, 32'd0);
        check("bltu_ready",     {31'd0, br_ready}, 32'd1);

        // ---------------- BGE not taken, back-to-back ----------------
        present(1'b0, 1'b0, 3'b101, 32'h400, 32'h8, 32'hFFFF_FFFF, 32'd1);
        step();
        br_valid = 1'b0;
        check("bge_un",         {31'd0, comp_un}, 32'd0);
        step();
        check("bge_rv",         {31'd0, resolve_valid}, 32'd1);
        check("bge_rt",         {31'd0, resolve_taken}, 32'd0);
        check("bge_flush",      {31'd0, flush}, 32'd0);

        // ---------------- BLT taken, negative immediate ----------------
        present(1'b0, 1'b0, 3'b100, 32'h200, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1);
        step();
        br_valid = 1'b0;
        step();
        check("blt_rt",         {31'd0, resolve_taken}, 32'd1);
        check("blt_redir",      {31'd0, redirect_valid}, 32'd1);
        check("blt_redir_pc",   redirect_pc, 32'h1F8);
        step();
        step();
        check("blt_ready",      {31'd0, br_ready}, 32'd1);

        // ---------------- JALR misaligned ----------------
        present(1'b0, 1'b1, 3'b011, 32'h500, 32'h0, 32'h203, 32'h7);
        step();
        br_valid = 1'b0;
        check("jalr_sel",       {29'd0, comp_sel}, 32'd0);
        step();
        check("jalr_misalign",  {31'd0, misalign}, 32'd1);
        check("jalr_rv",        {31'd0, resolve_valid}, 32'd1);
        check("jalr_rt",        {31'd0, resolve_taken}, 32'd1);
        check("jalr_redir",     {31'd0, redirect_valid}, 32'd0);
        check("jalr_flush",     {31'd0, flush}, 32'd0);
        check("jalr_illegal",   {31'd0, illegal}, 32'd0);
        check("jalr_ready",     {31'd0, br_ready}, 32'd1);

        // ---------------- JAL taken ----------------
        present(1'b1, 1'b0, 3'b000, 32'h1000, 32'h10, 32'd1, 32'd2);
        step();
        br_valid = 1'b0;
        step();
        check("jal_redir",      {31'd0, redirect_valid}, 32'd1);
        check("jal_redir_pc",   redirect_pc, 32'h1010);
        check("jal_misalign",   {31'd0, misalign}, 32'd0);
        step();
        step();

        // ---------------- BNE taken, target wraps ----------------
        present(1'b0, 1'b0, 3'b001, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd2);
        step();
        br_valid = 1'b0;
        step();
        check("bne_rt",         {31'd0, resolve_taken}, 32'd1);
        check("bne_redir_pc",   redirect_pc, 32'h10);
        step();
        step();

        // ---------------- reserved funct3 ----------------
        present(1'b0, 1'b0, 3'b010, 32'h600, 32'h40, 32'd3, 32'd3);
        step();
        br_valid = 1'b0;
        step();
        check("ill_illegal",    {31'd0, illegal}, 32'd1);
        check("ill_rv",         {31'd0, resolve_valid}, 32'd1);
        check("ill_rt",         {31'd0, resolve_taken}, 32'd0);
        check("ill_redir",      {31'd0, redirect_valid}, 32'd0);
        check("ill_flush",      {31'd0, flush}, 32'd0);
        step();
        check("ill_pulse_end",  {31'd0, illegal}, 32'd0);

        // 8 resolves so far: BEQ, BLT, JALR, JAL, BNE counted as taken.
`ifdef BRANCH_CTRL_STATS_EN
        check("stat_branches",  stat_branches, 32'd8);
        check("stat_taken",     stat_taken, 32'd5);
`else
        check("stat_branches",  stat_branches, 32'd0);
        check("stat_taken",     stat_taken, 32'd0);
`endif

        // ---------------- reset in the middle of FLUSH ----------------
        present(1'b0, 1'b0, 3'b000, 32'h700, 32'h4, 32'd9, 32'd9);
        step();
        br_valid = 1'b0;
        step();                       // T+2: FLUSH entered
        check("rf_flush",       {31'd0, flush}, 32'd1);
        rst = 1'b1;
        step();
        check("rf_flush_0",     {31'd0, flush}, 32'd0);
        check("rf_rv_0",        {31'd0, resolve_valid}, 32'd0);
        check("rf_redir_0",     {31'd0, redirect_valid}, 32'd0);
        check("rf_redir_pc_0",  redirect_pc, 32'd0);
        check("rf_comp_a_0",    comp_a, 32'd0);
        check("rf_stat_0",      stat_branches, 32'd0);
        check("rf_ready_rst",   {31'd0, br_ready}, 32'd0);
        rst = 1'b0;
        step();
        check("rf_ready",       {31'd0, br_ready}, 32'd1);
        check("rf_flush_1",     {31'd0, flush}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
